// File: rtl/elev_call_dispatcher.sv
// Elevator call dispatcher: latches floor calls and picks the next target using a sweep.
// Optional door over-time reporting is enabled by defining DISPATCH_OVERTIME_EN.
module elev_call_dispatcher #(
    parameter int DOOR_HOLD = 4,
    parameter int OT_LIMIT  = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] call_btn,
    input  logic [7:0] current_floor,
    input  logic       complete,
    input  logic       door_block,
    output logic [7:0] request_floor,
    output logic [7:0] pending,
    output logic       door_open,
    output logic       over_time,
    output logic       sweep_up,
    output logic       busy
);

    localparam int CW = $clog2(OT_LIMIT + 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(DOOR_HOLD - 1);
    localparam logic [CW-1:0] OT_MAX = CW'(OT_LIMIT);

    typedef enum logic [1:0] {
        IDLE,
        SELECT,
        MOVE,
        DOOR
    } state_t;

    state_t state, state_nxt;

    logic [CW-1:0] cnt, cnt_nxt;
    logic [7:0] pending_nxt;
    logic [7:0] request_nxt;
    logic sweep_nxt;
    logic hold_door;
    logic cf_onehot;
    logic at_call;
    logic call_here;
    logic [7:0] below_mask, above_mask;
    logic [7:0] up_hits, dn_hits;
    logic [7:0] tgt;
    logic tgt_found;
    logic tgt_flip;

    function automatic logic [7:0] lowest_bit(input logic [7:0] v);
        lowest_bit = v & (~v + 8'd1);
    endfunction

    function automatic logic [7:0] highest_bit(input logic [7:0] v);
        logic [7:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            if (v[i]) begin
                r = '0;
                r[i] = 1'b1;
            end
        end
        highest_bit = r;
    endfunction

`ifdef DISPATCH_OVERTIME_EN
    logic ot_q;

    assign hold_door = door_block;
    assign over_time = ot_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            ot_q <= 1'b0;
        end else if (state_nxt != DOOR) begin
            ot_q <= 1'b0;
        end else if (state == DOOR && cnt_nxt == OT_MAX) begin
            ot_q <= 1'b1;
        end
    end
`else
    logic unused_door_block;

    assign unused_door_block = door_block;
    assign hold_door = 1'b0;
    assign over_time = 1'b0;
`endif

    assign cf_onehot = (current_floor != 8'd0)
                    && ((current_floor & (current_floor - 8'd1)) == 8'd0);
    assign at_call = |(pending & current_floor);
    assign call_here = |(call_btn & current_floor);

    // Nearest call in the sweep direction, else nearest behind us with a reversal.
    always_comb begin
        below_mask = current_floor - 8'd1;
        above_mask = ~(current_floor | below_mask);
        up_hits = pending & above_mask;
        dn_hits = pending & below_mask;
        tgt = 8'd0;
        tgt_found = 1'b0;
        tgt_flip = 1'b0;
        if (sweep_up) begin
            if (|up_hits) begin
                tgt = lowest_bit(up_hits);
                tgt_found = 1'b1;
            end else if (|dn_hits) begin
                tgt = highest_bit(dn_hits);
                tgt_found = 1'b1;
                tgt_flip = 1'b1;
            end
        end else begin
            if (|dn_hits) begin
                tgt = highest_bit(dn_hits);
                tgt_found = 1'b1;
            end else if (|up_hits) begin
                tgt = lowest_bit(up_hits);
                tgt_found = 1'b1;
                tgt_flip = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if ((|pending) && cf_onehot) state_nxt = SELECT;
            end
            SELECT: begin
                if (at_call) state_nxt = DOOR;
                else if (tgt_found) state_nxt = MOVE;
                else state_nxt = IDLE;
            end
            MOVE: begin
                if (complete && current_floor == request_floor) state_nxt = DOOR;
            end
            DOOR: begin
                if (!call_here && cnt >= HOLD_LAST && !hold_door) begin
                    state_nxt = (|pending) ? SELECT : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
        door_open = (state == DOOR);
    end

    // In DOOR the current floor's bit is cleared every cycle so a press there is absorbed.
    always_comb begin
        pending_nxt = pending | call_btn;
        if (state == DOOR) begin
            pending_nxt = (pending | (call_btn & ~current_floor)) & ~current_floor;
        end else if (state_nxt == DOOR) begin
            pending_nxt = (pending & ~current_floor) | call_btn;
        end
    end

    always_comb begin
        cnt_nxt = '0;
        if (state == DOOR && state_nxt == DOOR && !call_here) begin
            cnt_nxt = (cnt == OT_MAX) ? cnt : cnt + CW'(1);
        end
    end

    always_comb begin
        request_nxt = request_floor;
        sweep_nxt = sweep_up;
        if (state == IDLE) begin
            request_nxt = current_floor;
        end else if (state == SELECT && state_nxt == MOVE) begin
            request_nxt = tgt;
            sweep_nxt = sweep_up ^ tgt_flip;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pending <= 8'd0;
            request_floor <= 8'h01;
            sweep_up <= 1'b1;
            cnt <= '0;
        end else begin
            pending <= pending_nxt;
            request_floor <= request_nxt;
            sweep_up <= sweep_nxt;
            cnt <= cnt_nxt;
        end
    end

endmodule

// File: doc/elev_call_dispatcher.md
ELEV_CALL_DISPATCHER -- requirements
Module: elev_call_dispatcher

Interface
REQ-001 SHALL have parameter DOOR_HOLD, default 4, door-open dwell in clk cycles (min 1).
REQ-002 SHALL have parameter OT_LIMIT, default 16, door-open cycles before over_time (> DOOR_HOLD).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port call_btn  input  8  per-floor call buttons, bit i = floor i, level, may be multi-hot.
REQ-006 SHALL have port current_floor  input  8  one-hot car position from elevator controller.
REQ-007 SHALL have port complete  input  1  controller arrived at request_floor.
REQ-008 SHALL have port door_block  input  1  door obstruction sensor.
REQ-009 SHALL have port request_floor  output  8  one-hot registered target driven to controller.
REQ-010 SHALL have port pending  output  8  latched outstanding calls.
REQ-011 SHALL have port door_open  output  1  door open command.
REQ-012 SHALL have port over_time  output  1  door held open too long, to controller.
REQ-013 SHALL have port sweep_up  output  1  current sweep direction, 1 = up.
REQ-014 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-015 SHALL implement FSM states IDLE, SELECT, MOVE, DOOR.
REQ-016 SHALL OR call_btn into pending every cycle; a press at cycle n appears in pending at n+1.
REQ-017 SHALL, in IDLE, load request_floor with current_floor each cycle so the controller sees request equal to position.
REQ-018 SHALL go IDLE->SELECT when pending != 0 and current_floor is one-hot; a non-one-hot current_floor holds IDLE.
REQ-019 SHALL, in SELECT, go to DOOR if the pending bit at current_floor is set; otherwise pick the nearest pending floor in the sweep_up direction, else reverse sweep_up and pick the nearest in the new direction; load it into request_floor and go to MOVE, all in one cycle.
REQ-020 SHALL hold request_floor stable throughout MOVE; new calls only update pending.
REQ-021 SHALL go MOVE->DOOR when complete=1 and current_floor == request_floor.
REQ-022 SHALL, on DOOR entry, clear the pending bit of current_floor, assert door_open, and zero the door counter.
REQ-023 SHALL, in DOOR, absorb a call at current_floor: do not set pending, restart the counter.
REQ-024 SHALL leave DOOR when the counter reaches DOOR_HOLD-1 with door_block=0: to SELECT if pending != 0, else IDLE; door_open deasserts on exit.
REQ-025 SHALL keep door_open=1 and the counter running while door_block=1 (saturating at OT_LIMIT).
REQ-026 SHALL, when a simultaneous call and clear target the same bit, give clear priority only in DOOR at current_floor; otherwise set wins.

Reset
REQ-027 SHALL, with reset=1 at posedge, set state=IDLE, pending=0, request_floor=8'h01, door_open=0, over_time=0, sweep_up=1, busy=0, counter=0.
REQ-028 SHALL, on reset mid-MOVE or mid-DOOR, drop all outstanding calls and close the door the next cycle.

Configuration
REQ-029 SHALL, with DISPATCH_OVERTIME_EN defined, assert over_time registered when the DOOR counter reaches OT_LIMIT and hold it until door_block=0 and DOOR exits.
REQ-030 SHALL, without DISPATCH_OVERTIME_EN, tie over_time to 0 and ignore door_block; DOOR exits strictly after DOOR_HOLD cycles.

Verification
REQ-031 SHALL cover: reset, current_floor=8'h04, no calls -> IDLE, request_floor=8'h04 next cycle, busy=0.
REQ-032 SHALL cover: at floor 8'h04 with sweep_up=1, press 8'h41 -> targets 8'h40 first, then sweep_up=0 and 8'h01.
REQ-033 SHALL cover: press 8'h04 while at 8'h04 -> SELECT->DOOR without MOVE, door_open for DOOR_HOLD=4 cycles, pending[2]=0.
REQ-034 SHALL cover: press 8'h10 during MOVE toward 8'h80 -> request_floor stays 8'h80, pending=8'h90 until arrival.
REQ-035 SHALL cover: with DISPATCH_OVERTIME_EN, door_block=1 for 20 cycles in DOOR -> over_time=1 at counter 16, cleared after release and exit.
REQ-036 SHALL cover: reset asserted mid-MOVE with pending=8'hF0 -> pending=0, state IDLE, door_open=0 next cycle.
